// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and byte-enable helper for the LSU.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    function automatic logic [3:0] gen_be(input logic [2:0] funct3, input logic [1:0] o);
        return funct3[1:0] == 2'b00 ? 4'b0001 << o :
               funct3[1:0] == 2'b01 ? (o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request/grant data-memory port between the LSU (master) and memory (slave).
interface lsu_mem_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed byte/half of a load word down and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    always_comb begin
        sh = funct3_i[1:0] == 2'b00 ? rdata_i >> {off_i, 3'b000} :
             funct3_i[1:0] == 2'b01 ? rdata_i >> {off_i[1], 4'b0000} : rdata_i;
        data_o = funct3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                 funct3_i == F3_BU ? {24'b0, sh[7:0]} :
                 funct3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3_i == F3_HU ? {16'b0, sh[15:0]} : sh;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store controller stalling the core until each access retires.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with lsu_err instead of issuing them.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           MemRead,
    input  logic           MemWrite,
    input  logic [2:0]     funct3,
    input  logic [31:0]    AluResult,
    input  logic [31:0]    StoreVal,
    output logic           stall,
    output logic [31:0]    LoadVal,
    output logic           lsu_err,
    lsu_mem_ctrl_if.master dmem
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic        ill, mis;
    logic [31:0] aligned;

    lsu_load_align u_align (
        .rdata_i (dmem.rdata),
        .funct3_i(f3_q),
        .off_i   (off_q),
        .data_o  (aligned)
    );

    always_comb begin
        ill = MemWrite ? (funct3 >= 3'b011) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
        mis = (funct3[1:0] == 2'b01 && AluResult[0]) || (funct3[1:0] == 2'b10 && AluResult[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        err_d   = err_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: if (MemRead || MemWrite) begin
                we_d    = MemWrite;
                f3_d    = funct3;
                off_d   = AluResult[1:0];
                addr_d  = {AluResult[31:2], 2'b00};
                be_d    = (ill || mis) ? 4'b0000 : gen_be(funct3, AluResult[1:0]);
                wdata_d = funct3[1:0] == 2'b00 ? {4{StoreVal[7:0]}} :
                          funct3[1:0] == 2'b01 ? {2{StoreVal[15:0]}} : StoreVal;
                err_d   = ill || mis;
                load_d  = (ill || mis) ? 32'b0 : load_q;
                state_d = (ill || mis) ? DONE : REQ;
            end
            REQ: if (dmem.gnt) begin
                state_d = we_q ? DONE : WAIT;
                wd_d    = '0;
            end
            WAIT: if (dmem.rvalid) begin
                load_d  = aligned;
                state_d = DONE;
            end else begin
                wd_d = wd_q + 1'b1;
                if (WAIT_TIMEOUT != 0 && wd_d == TO_W'(WAIT_TIMEOUT)) begin
                    load_d  = 32'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            addr_q  <= 32'b0;
            be_q    <= 4'b0;
            wdata_q <= 32'b0;
            load_q  <= 32'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign stall      = (state_q == IDLE && (MemRead || MemWrite)) || state_q == REQ || state_q == WAIT;
    assign LoadVal    = load_q;
    assign lsu_err    = state_q == DONE && err_q;
    assign dmem.req   = state_q == REQ;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

endmodule
